// File: rtl/overlap_framer_pkg.sv
// Shared definitions for the overlapping FFT input framer: default sample width,
// pointer sizing helper and the framer FSM state encoding.
package overlap_framer_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One extra bit beyond the address lets full and empty be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/overlap_framer_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module sample_ram
    import overlap_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 256
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/overlap_framer.sv
// Overlapping N-sample framer: buffers a real stream and emits one FFT burst
// every HOP input samples, zero-padding the tail of a flushed stream.
module overlap_framer
    import overlap_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 128,
    parameter int HOP   = 64,
    parameter int BUF   = 2 * N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    input  logic             fft_ready,
    output logic             di_en,
    output logic [WIDTH-1:0] di_re,
    output logic [WIDTH-1:0] di_im,
    output logic             di_first,
    output logic [15:0]      frame_idx,
    output logic             done
);

    localparam int PW = ptr_width(BUF);
    localparam int AW = PW - 1;

    logic [1:0]       state;
    logic [PW-1:0]    wr, fs, last_ptr, cnt;
    logic [PW-1:0]    occ, rem, fs_hop;
    logic             flush_pend, fs_lt_last, can_start, start;
    logic             last_rd, next_b2b, rd_en, rd_first, pad_rd;
    logic             first_q, pad_q, xfer;
    logic [AW-1:0]    rd_addr;
    logic [15:0]      frame_cnt;
    logic [WIDTH-1:0] rd_data;

    assign occ    = wr - fs;
    assign rem    = last_ptr - fs;
    assign fs_hop = fs + PW'(HOP);

    // fs may overshoot last_ptr by less than HOP, which shows up as a wrapped rem > BUF.
    assign fs_lt_last = (rem != '0) && (rem <= PW'(BUF));

    assign din_ready = reset && (occ < PW'(BUF)) && !flush_pend &&
                       ((state == ST_IDLE) || (state == ST_EMIT));
    assign xfer      = din_valid && din_ready;

    assign can_start = fft_ready && (flush_pend ? fs_lt_last : (occ >= PW'(N)));
    assign start     = ((state == ST_IDLE) || (state == ST_FLUSH)) && can_start;
    assign last_rd   = (state == ST_EMIT) && (cnt == PW'(N - 1));
    assign next_b2b  = last_rd && !flush_pend && fft_ready && ((wr - fs_hop) >= PW'(N));

    // cnt is 0 outside EMIT, so the frame-start read in IDLE/FLUSH addresses fs itself.
    assign rd_en    = start || (state == ST_EMIT);
    assign rd_addr  = fs[AW-1:0] + cnt[AW-1:0];
    assign rd_first = rd_en && (cnt == '0);
    assign pad_rd   = flush_pend && (cnt >= rem);

    sample_ram #(
        .WIDTH (WIDTH),
        .DEPTH (BUF)
    ) u_ram (
        .clock   (clock),
        .wr_en   (xfer),
        .wr_addr (wr[AW-1:0]),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wr         <= '0;
            fs         <= '0;
            last_ptr   <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            di_en      <= 1'b0;
            first_q    <= 1'b0;
            pad_q      <= 1'b0;
            frame_idx  <= '0;
            frame_cnt  <= '0;
        end else begin
            di_en   <= rd_en;
            first_q <= rd_first;
            pad_q   <= pad_rd;

            if (xfer) begin
                wr <= wr + 1'b1;
                if (din_last) begin
                    flush_pend <= 1'b1;
                    last_ptr   <= wr + 1'b1;
                end
            end

            if (rd_first) begin
                frame_idx <= frame_cnt;
                frame_cnt <= frame_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_EMIT;
                        cnt   <= PW'(1);
                    end else if (flush_pend) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_EMIT: begin
                    if (last_rd) begin
                        fs  <= fs_hop;
                        cnt <= '0;
                        if (next_b2b)
                            state <= ST_EMIT;
                        else if (flush_pend)
                            state <= ST_FLUSH;
                        else
                            state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (start) begin
                        state <= ST_EMIT;
                        cnt   <= PW'(1);
                    end else if (!fs_lt_last) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    wr         <= '0;
                    fs         <= '0;
                    flush_pend <= 1'b0;
                    frame_idx  <= '0;
                    frame_cnt  <= '0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign di_first = first_q;
    assign di_re    = (di_en && !pad_q) ? rd_data : '0;
    assign di_im    = '0;
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_overlap_framer.sv
// Randomised self-checking bench for overlap_framer (N=8, BUF=16; HOP=4 and HOP=8 instances).
module tb_overlap_framer;

    localparam int W  = 16;
    localparam int NN = 8;

    logic          clock, reset;
    logic [W-1:0]  s_data;
    logic          s_valid, s_last, fft_ready, sel, rnd_fr;

    logic          va, vb, ready_a, ready_b, en_a, en_b, first_a, first_b, done_a, done_b;
    logic [W-1:0]  re_a, re_b, im_a, im_b;
    logic [15:0]   idx_a, idx_b;

    logic          m_en, m_first, m_done, m_ready;
    logic [W-1:0]  m_re, m_im;
    logic [15:0]   m_idx;

    assign va = s_valid & ~sel;
    assign vb = s_valid & sel;

    overlap_framer #(.WIDTH(W), .N(NN), .HOP(4), .BUF(16)) u_dut_a (
        .clock(clock), .reset(reset), .din(s_data), .din_valid(va), .din_last(s_last),
        .din_ready(ready_a), .fft_ready(fft_ready), .di_en(en_a), .di_re(re_a), .di_im(im_a),
        .di_first(first_a), .frame_idx(idx_a), .done(done_a));

    overlap_framer #(.WIDTH(W), .N(NN), .HOP(8), .BUF(16)) u_dut_b (
        .clock(clock), .reset(reset), .din(s_data), .din_valid(vb), .din_last(s_last),
        .din_ready(ready_b), .fft_ready(fft_ready), .di_en(en_b), .di_re(re_b), .di_im(im_b),
        .di_first(first_b), .frame_idx(idx_b), .done(done_b));

    assign m_en    = sel ? en_b    : en_a;
    assign m_re    = sel ? re_b    : re_a;
    assign m_im    = sel ? im_b    : im_a;
    assign m_first = sel ? first_b : first_a;
    assign m_idx   = sel ? idx_b   : idx_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_ready = sel ? ready_b : ready_a;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Reference model: frame k position i carries stream sample k*HOP+i, or 0 beyond the stream end.
    logic [W-1:0] acc[$];
    logic [W-1:0] capf [4][NN];
    bit           last_seen = 0;
    bit           expect_done = 0;
    int           k = 0, i = 0, p, last_frames = 0, done_cnt = 0;
    int           hop_cur;

    assign hop_cur = sel ? 8 : 4;

    always @(negedge clock) begin
        if (!reset) begin
            acc.delete(); last_seen = 0; k = 0; i = 0; expect_done = 0;
        end else begin
            chk("done", {31'd0, m_done}, {31'd0, expect_done});
            if (expect_done) begin
                last_frames = k;
                done_cnt++;
                acc.delete(); last_seen = 0; k = 0; i = 0; expect_done = 0;
            end else begin
                if (i != 0) chk("contiguous", {31'd0, m_en}, 32'd1);
                if (m_en) begin
                    p = k * hop_cur + i;
                    if (p >= acc.size() && !last_seen)
                        chk("sample_buffered", p, acc.size() - 1);
                    else
                        chk("di_re", m_re, (p < acc.size()) ? acc[p] : '0);
                    chk("di_im", m_im, 0);
                    chk("di_first", {31'd0, m_first}, (i == 0) ? 32'd1 : 32'd0);
                    if (i == 0) chk("frame_idx", m_idx, k & 16'hffff);
                    if (k < 4) capf[k][i] = m_re;
                    i++;
                    if (i == NN) begin
                        i = 0;
                        k++;
                        if (last_seen && k * hop_cur >= acc.size()) expect_done = 1;
                    end
                end
            end
        end
    end

    task automatic send(input int n, input int base, input int gap, input bit rnd_data, input bit with_last);
        int j = 0;
        int guard = 0;
        while (j < n) begin
            @(negedge clock);
            if (rnd_fr) fft_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < gap) begin
                s_valid = 0; s_last = 0;
            end else begin
                s_valid = 1;
                s_data  = rnd_data ? W'($urandom_range(0, 65535)) : W'(base + j);
                s_last  = with_last && (j == n - 1);
            end
            #1;
            if (s_valid && m_ready) begin
                acc.push_back(s_data);
                if (s_last) last_seen = 1;
                j++;
            end
            guard++;
            if (guard > 3000) begin
                chk("send_timeout", j, n);
                break;
            end
        end
        @(negedge clock);
        s_valid = 0; s_last = 0;
    endtask

    task automatic wait_done();
        int start_cnt = done_cnt;
        int cyc = 0;
        while (done_cnt == start_cnt && cyc < 2000) begin
            @(negedge clock);
            if (rnd_fr) fft_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk("done_seen", done_cnt - start_cnt, 1);
        #1;
    endtask

    initial begin
        int cyc;
        reset = 0; s_valid = 0; s_last = 0; s_data = '0; fft_ready = 0; sel = 0; rnd_fr = 0;
        #1;
        chk("rst_ready", {31'd0, ready_a}, 0);
        chk("rst_en", {31'd0, en_a}, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_done", {31'd0, done_a}, 0);
        repeat (2) @(negedge clock);
        reset = 1;
        #1 chk("rel_ready", {31'd0, ready_a}, 1);

        // Ramp 0..15, HOP=4
        fft_ready = 1;
        send(16, 0, 0, 0, 1);
        wait_done();
        chk("t1_frames", last_frames, 4);
        for (int n = 0; n < NN; n++)
            chk("t1_tail", capf[3][n], (n < 4) ? 12 + n : 0);

        // Ramp 0..23, HOP=8
        sel = 1;
        send(24, 0, 0, 0, 1);
        wait_done();
        chk("t2_frames", last_frames, 3);
        chk("t2_f2_first", capf[2][0], 16);
        chk("t2_f2_last", capf[2][7], 23);
        sel = 0;

        // Backpressure with fft_ready held low
        fft_ready = 0;
        send(16, 0, 0, 0, 0);
        #1 chk("t3_full_ready", {31'd0, m_ready}, 0);
        fft_ready = 1;
        send(4, 16, 0, 0, 1);
        wait_done();
        chk("t3_frames", last_frames, 5);
        for (int n = 0; n < NN; n++) begin
            chk("t3_f0", capf[0][n], n);
            chk("t3_f1", capf[1][n], 4 + n);
        end

        // Short stream 5,6,7
        send(3, 5, 0, 0, 1);
        wait_done();
        chk("t4_frames", last_frames, 1);
        for (int n = 0; n < NN; n++)
            chk("t4_pad", capf[0][n], (n < 3) ? 5 + n : 0);

        // Reset in the middle of a frame
        fft_ready = 0;
        send(12, 100, 0, 0, 0);
        fft_ready = 1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock);
            if (m_first) break;
            cyc++;
        end
        chk("t5_first_seen", {31'd0, m_first}, 1);
        repeat (3) @(negedge clock);
        chk("t5_en_before", {31'd0, m_en}, 1);
        #2 reset = 0;
        #1;
        chk("t5_en_abort", {31'd0, en_a}, 0);
        chk("t5_ready_rst", {31'd0, ready_a}, 0);
        chk("t5_idx_rst", idx_a, 0);
        repeat (2) @(negedge clock);
        #2 reset = 1;
        #1 chk("t5_ready_rel", {31'd0, ready_a}, 1);
        send(16, 0, 0, 0, 1);
        wait_done();
        chk("t5_frames", last_frames, 4);
        chk("t5_f0_first", capf[0][0], 0);

        // Ramp 0..31 with 50% input gaps
        send(32, 0, 50, 0, 1);
        wait_done();
        chk("t6_frames", last_frames, 8);

        // Random data, gaps and fft_ready on both instances
        rnd_fr = 1;
        for (int r = 0; r < 6; r++) begin
            sel = r[0];
            send($urandom_range(1, 40), 0, 30, 1, 1);
            wait_done();
        end
        rnd_fr = 0;
        fft_ready = 0;

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
